multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//  Controls the shared iterative multiply/divide resource in the execute stage.
//  - Accepts a one-cycle MULT or DIV start pulse from the pipeline.
//  - Latches the operands and issues a one-cycle load to the Booth multiplier or
//    the divider.
//  - Counts the iterations, then presents a 32-bit result with a one-cycle ready
//    strobe and an exception flag.
//  - Drives the pipeline stall while the resource is busy.
// PARAMETERS
//  XLEN      32  operand/result width
//  ITER_MUL  32  multiplier iterations; one per clock after load
//  ITER_DIV  32  divider iterations; one per clock after load
// PORTS
//  clock           in   1        single clock; all state updates on rising edge
//  reset           in   1        synchronous, active-high
//  ctrl_MULT       in   1        start-multiply pulse
//  ctrl_DIV        in   1        start-divide pulse
//  data_operandA   in   XLEN     multiplicand / dividend, sampled on start
//  data_operandB   in   XLEN     multiplier / divisor, sampled on start
//  mul_result      in   2*XLEN   product from the Booth multiplier
//  div_quotient    in   XLEN     quotient from the divider
//  op_a            out  XLEN     latched operand A to both units
//  op_b            out  XLEN     latched operand B to both units
//  mul_ctrl        out  1        multiplier load strobe (its CTRL input)
//  div_ctrl        out  1        divider load strobe
//  data_result     out  XLEN     result, valid only while data_resultRDY=1
//  data_exception  out  1        overflow / divide-by-zero, qualified by RDY
//  data_resultRDY  out  1        one-cycle result-valid strobe
//  stall           out  1        holds the pipeline; combinational
// BEHAVIOUR
//  FSM states: IDLE, LOAD, RUN, DONE. The state register is encoded.
//  Reset:
//   - Next edge forces IDLE, the counter to 0 and op_a/op_b/op_kind to 0.
//   - All outputs read 0 in IDLE after reset.
//   - Reset mid-operation abandons the operation; no RDY is produced.
//  Start (cycle T, state IDLE or DONE):
//   - A start is ctrl_MULT | ctrl_DIV.
//   - If both pulses are high, MULT has priority and DIV is ignored.
//   - At edge T, op_a, op_b and op_kind are latched.
//   - Next state is LOAD, except for DIV with data_operandB==0, which goes to
//     DONE (divide-by-zero early-out).
//  LOAD (T+1):
//   - mul_ctrl=1 (MULT) or div_ctrl=1 (DIV) for exactly this cycle.
//   - The counter is cleared; next state is RUN.
//  RUN (T+2 .. T+1+ITER):
//   - The counter increments each cycle.
//   - Exit to DONE when count==ITER-1, so RUN lasts exactly ITER cycles.
//   - ITER is ITER_MUL or ITER_DIV according to op_kind.
//  DONE (T+2+ITER):
//   - data_resultRDY=1 for one cycle.
//   - MULT: data_result=mul_result[XLEN-1:0];
//     data_exception = (mul_result[2*XLEN-1:XLEN] != {XLEN{mul_result[XLEN-1]}}).
//   - DIV: data_result=div_quotient; data_exception=0.
//   - Divide-by-zero early-out: data_result=0, data_exception=1, RDY at T+1.
//   - Next state is IDLE, or LOAD if a new start arrives in this cycle
//     (back-to-back issue).
//  Outside DONE, data_result=0 and data_exception=0.
//  op_a and op_b are held stable from T+1 until the next accepted start.
//  stall = start_in_IDLE | (state==LOAD) | (state==RUN). It is low in DONE so
//  the pipeline captures the result.
//  Start pulses in LOAD or RUN are ignored; the stall makes them illegal upstream.
//  Latency: MULT ITER_MUL+2 clocks from the start edge to RDY (34 at default).
//  Unit outputs are consumed only in DONE; no width extension is performed.
// STRUCTURE
//  Shared include multdiv_defs.vh holds:
//   - state encodings S_IDLE, S_LOAD, S_RUN, S_DONE (2 bits);
//   - OP_MUL/OP_DIV;
//   - default ITER constants.
//  One sub-module, iter_counter:
//   - synchronous clear, enable, terminal-count output;
//   - width = clog2(max ITER).
//  The FSM and output mux stay in multdiv_sequencer.
// TESTING
//  1) reset held 3 cycles with ctrl_MULT=1 -> no mul_ctrl, RDY=0, stall=0
//     after release.
//  2) MULT A=7, B=-3, mul_result model=-21 -> mul_ctrl at T+1, RDY at T+34,
//     result=0xFFFFFFEB, exception=0, stall high T..T+33.
//  3) MULT A=0x40000000, B=4 -> RDY at T+34, result=0, exception=1 (overflow).
//  4) DIV A=100, B=0 -> no div_ctrl, RDY at T+1, result=0, exception=1.
//  5) ctrl_MULT and ctrl_DIV together, A=5, B=6 -> only mul_ctrl pulses,
//     result=30. Then new MULT in the DONE cycle -> LOAD next cycle,
//     second RDY 34 cycles later.
//  6) reset asserted in RUN count 10 -> IDLE next cycle, no RDY within 40 cycles,
//     next MULT completes normally.

Source files
------------

// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants and types for the multiply/divide sequencer.
// No logic here; state encodings, operation kinds and default sizes.
// Imported by the sequencer top and its iteration counter.
package multdiv_sequencer_pkg;

   localparam int DEF_XLEN     = 32;
   localparam int DEF_ITER_MUL = 32;
   localparam int DEF_ITER_DIV = 32;

   // 2-bit encoded controller states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // which unit the latched operation belongs to
   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_kind_t;

   // counter width able to hold the largest terminal count (at least 1 bit)
   function automatic int cnt_width(input int iter_mul, input int iter_div);
      int m;
      m = (iter_mul > iter_div) ? iter_mul : iter_div;
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/multdiv_sequencer_iter_counter.sv
// Iteration counter: counts enabled cycles, flags when count equals last.
// Latency: count updates on the clock edge; tc is combinational from count.
// No backpressure; clear wins over enable.
module iter_counter #(
   parameter int W = 5
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic         tc
);

   logic [W-1:0] count;

   // synchronous clear has priority over counting
   always_ff @(posedge clock) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == last);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the shared iterative multiplier/divider: latch, load, iterate, report.
// Latency: ITER+2 clocks from start edge to result strobe; divide-by-zero in 1.
// Backpressure: stall held from the start cycle through the last RUN cycle.
module multdiv_sequencer
   import multdiv_sequencer_pkg::*;
#(
   parameter int XLEN     = DEF_XLEN,
   parameter int ITER_MUL = DEF_ITER_MUL,
   parameter int ITER_DIV = DEF_ITER_DIV
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ctrl_MULT,
   input  logic              ctrl_DIV,
   input  logic [XLEN-1:0]   data_operandA,
   input  logic [XLEN-1:0]   data_operandB,
   input  logic [2*XLEN-1:0] mul_result,
   input  logic [XLEN-1:0]   div_quotient,
   output logic [XLEN-1:0]   op_a,
   output logic [XLEN-1:0]   op_b,
   output logic              mul_ctrl,
   output logic              div_ctrl,
   output logic [XLEN-1:0]   data_result,
   output logic              data_exception,
   output logic              data_resultRDY,
   output logic              stall
);

   localparam int CW = cnt_width(ITER_MUL, ITER_DIV);

   state_t   state, state_nxt;
   op_kind_t op_kind;
   logic     div_zero;
   logic     start, accept, new_dz;
   logic     cnt_clr, cnt_en, cnt_tc;
   logic [CW-1:0] cnt_last;

   // a start is only honoured outside reset and when the resource is free
   assign start  = (ctrl_MULT | ctrl_DIV) & ~reset;
   assign accept = start & ((state == S_IDLE) | (state == S_DONE));
   // MULT has priority, so a divide-by-zero needs DIV without MULT
   assign new_dz = ~ctrl_MULT & ctrl_DIV & (data_operandB == '0);

   assign cnt_last = (op_kind == OP_MUL) ? CW'(ITER_MUL - 1) : CW'(ITER_DIV - 1);

   iter_counter #(.W(CW)) u_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .last  (cnt_last),
      .tc    (cnt_tc)
   );

   // state register and operand latch; operands only move on an accepted start
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         op_a     <= '0;
         op_b     <= '0;
         op_kind  <= OP_MUL;
         div_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_a     <= data_operandA;
            op_b     <= data_operandB;
            op_kind  <= ctrl_MULT ? OP_MUL : OP_DIV;
            div_zero <= new_dz;
         end
      end
   end

   // next-state and unit strobes
   always_comb begin
      state_nxt      = state;
      mul_ctrl       = 1'b0;
      div_ctrl       = 1'b0;
      cnt_clr        = 1'b0;
      cnt_en         = 1'b0;
      data_resultRDY = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = new_dz ? S_DONE : S_LOAD;
         end
         S_LOAD: begin
            mul_ctrl  = (op_kind == OP_MUL);
            div_ctrl  = (op_kind == OP_DIV);
            cnt_clr   = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            cnt_en = 1'b1;
            if (cnt_tc) state_nxt = S_DONE;
         end
         S_DONE: begin
            data_resultRDY = 1'b1;
            if (accept) state_nxt = new_dz ? S_DONE : S_LOAD;
            else        state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // result mux: unit outputs are only looked at in DONE
   always_comb begin
      data_result    = '0;
      data_exception = 1'b0;
      if (state == S_DONE) begin
         if (div_zero) begin
            data_exception = 1'b1;
         end else if (op_kind == OP_MUL) begin
            data_result    = mul_result[XLEN-1:0];
            data_exception = (mul_result[2*XLEN-1:XLEN] != {XLEN{mul_result[XLEN-1]}});
         end else begin
            data_result = div_quotient;
         end
      end
   end

   // low in DONE so the pipeline can capture the result that cycle
   assign stall = (accept & (state == S_IDLE)) | (state == S_LOAD) | (state == S_RUN);

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

   localparam int ITER_MUL = 32;
   localparam int ITER_DIV = 32;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_operandA, data_operandB;
   logic [63:0] mul_result;
   logic [31:0] div_quotient;
   logic [31:0] op_a, op_b, data_result;
   logic        mul_ctrl, div_ctrl, data_exception, data_resultRDY, stall;

   multdiv_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .mul_result     (mul_result),
      .div_quotient   (div_quotient),
      .op_a           (op_a),
      .op_b           (op_b),
      .mul_ctrl       (mul_ctrl),
      .div_ctrl       (div_ctrl),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .stall          (stall)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at t=%0t actual=%0h required=%0h", nm, $time, act, req);
      end
   endtask

   // ---------------- behavioural model ----------------
   // An accepted operation is described by the cycle of its load strobe and
   // the cycle of its result; everything else follows from cycle arithmetic.
   int          cyc      = 0;
   int          rdy_cyc  = -1;
   int          load_cyc = -1;
   logic [31:0] m_a = '0, m_b = '0;
   bit          m_div = 1'b0, m_dz = 1'b0;
   bit          md_start, md_busy;
   bit          cmp_en = 1'b0;

   logic signed [63:0] prod_s;
   assign prod_s       = $signed({{32{m_a[31]}}, m_a}) * $signed({{32{m_b[31]}}, m_b});
   assign mul_result   = prod_s;
   assign div_quotient = (m_b == 32'd0) ? 32'hFFFF_FFFF : (m_a / m_b);

   always @(posedge clock) begin
      md_start = (ctrl_MULT || ctrl_DIV) && !reset;
      md_busy  = (rdy_cyc >= cyc) && (cyc != rdy_cyc);
      if (reset) begin
         rdy_cyc = -1; load_cyc = -1;
         m_a = '0; m_b = '0; m_div = 1'b0; m_dz = 1'b0;
      end else if (md_start && !md_busy) begin
         m_a   = data_operandA;
         m_b   = data_operandB;
         m_div = !ctrl_MULT;
         m_dz  = m_div && (data_operandB == 32'd0);
         if (m_dz) begin
            load_cyc = -1;
            rdy_cyc  = cyc + 1;
         end else begin
            load_cyc = cyc + 1;
            rdy_cyc  = cyc + 2 + (m_div ? ITER_DIV : ITER_MUL);
         end
      end
      cyc++;
   end

   // ---------------- per-cycle compare + monitor ----------------
   int          rdy_cnt = 0, mul_cnt = 0, div_cnt = 0;
   int          last_rdy_cyc = -1, last_mul_cyc = -1;
   logic [31:0] last_res;
   logic        last_exc;
   bit          c_inflight, c_done, c_start, e_stall, e_exc;
   logic [31:0] e_res;

   always @(negedge clock) begin
      if (cmp_en) begin
         c_inflight = (rdy_cyc >= cyc);
         c_done     = (cyc == rdy_cyc);
         c_start    = (ctrl_MULT || ctrl_DIV) && !reset;
         e_res = '0;
         e_exc = 1'b0;
         if (c_done) begin
            if (m_dz) begin
               e_exc = 1'b1;
            end else if (m_div) begin
               e_res = m_a / m_b;
            end else begin
               e_res = prod_s[31:0];
               e_exc = (prod_s > 64'sd2147483647) || (prod_s < -64'sd2147483648);
            end
         end
         e_stall = (c_inflight && !c_done) || (c_start && !c_inflight);
         chk("cyc_rdy",      {63'd0, data_resultRDY}, {63'd0, c_done});
         chk("cyc_result",   {32'd0, data_result},    {32'd0, e_res});
         chk("cyc_exc",      {63'd0, data_exception}, {63'd0, e_exc});
         chk("cyc_mul_ctrl", {63'd0, mul_ctrl}, {63'd0, (cyc == load_cyc) && !m_div});
         chk("cyc_div_ctrl", {63'd0, div_ctrl}, {63'd0, (cyc == load_cyc) && m_div});
         chk("cyc_stall",    {63'd0, stall},          {63'd0, e_stall});
         chk("cyc_op_a",     {32'd0, op_a},           {32'd0, m_a});
         chk("cyc_op_b",     {32'd0, op_b},           {32'd0, m_b});
         if (data_resultRDY) begin
            rdy_cnt++;
            last_rdy_cyc = cyc;
            last_res     = data_result;
            last_exc     = data_exception;
         end
         if (mul_ctrl) begin mul_cnt++; last_mul_cyc = cyc; end
         if (div_ctrl) div_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   int t0;

   // drive a one-cycle start in the current cycle; returns one cycle later
   task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
      t0 = cyc;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
   endtask

   task automatic wait_rdy(input string nm);
      int snap;
      snap = rdy_cnt;
      for (int i = 0; i < 60 && rdy_cnt == snap; i++) @(posedge clock);
      #1;
      chk({nm, "_rdy_seen"}, {63'd0, rdy_cnt != snap}, 64'd1);
   endtask

   int mc, dc, t1, rc;

   initial begin
      reset = 1'b1; ctrl_MULT = 1'b1; ctrl_DIV = 1'b0;
      data_operandA = 32'd11; data_operandB = 32'd13;
      // 1) reset with a start pulse held high
      @(posedge clock); #1; cmp_en = 1'b1;
      repeat (2) @(posedge clock);
      #1; reset = 1'b0; ctrl_MULT = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_mul_ctrl_cnt", 64'(mul_cnt), 64'd0);
      chk("rst_rdy",   {63'd0, data_resultRDY}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
      chk("rst_op_a",  {32'd0, op_a}, 64'd0);

      // 2) MULT 7 * -3
      mc = mul_cnt;
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      wait_rdy("mul7x-3");
      chk("mul7x-3_lat",    64'(last_rdy_cyc - t0), 64'd34);
      chk("mul7x-3_load",   64'(last_mul_cyc - t0), 64'd1);
      chk("mul7x-3_result", {32'd0, last_res}, 64'h0000_0000_FFFF_FFEB);
      chk("mul7x-3_exc",    {63'd0, last_exc}, 64'd0);
      chk("mul7x-3_loads",  64'(mul_cnt - mc), 64'd1);

      // 3) MULT overflow 0x40000000 * 4
      start_op(1'b1, 1'b0, 32'h4000_0000, 32'd4);
      wait_rdy("mul_ovf");
      chk("mul_ovf_lat",    64'(last_rdy_cyc - t0), 64'd34);
      chk("mul_ovf_result", {32'd0, last_res}, 64'd0);
      chk("mul_ovf_exc",    {63'd0, last_exc}, 64'd1);

      // 4) DIV by zero early-out
      dc = div_cnt;
      start_op(1'b0, 1'b1, 32'd100, 32'd0);
      wait_rdy("div0");
      chk("div0_lat",    64'(last_rdy_cyc - t0), 64'd1);
      chk("div0_result", {32'd0, last_res}, 64'd0);
      chk("div0_exc",    {63'd0, last_exc}, 64'd1);
      chk("div0_loads",  64'(div_cnt - dc), 64'd0);

      // normal DIV 100 / 7
      start_op(1'b0, 1'b1, 32'd100, 32'd7);
      wait_rdy("div100_7");
      chk("div100_7_lat",    64'(last_rdy_cyc - t0), 64'd34);
      chk("div100_7_result", {32'd0, last_res}, 64'd14);
      chk("div100_7_loads",  64'(div_cnt - dc), 64'd1);

      // 5) both pulses: MULT wins; then back-to-back MULT in DONE
      mc = mul_cnt; dc = div_cnt;
      start_op(1'b1, 1'b1, 32'd5, 32'd6);
      t1 = t0;
      repeat (33) @(posedge clock);
      #1;
      chk("both_done_rdy",    {63'd0, data_resultRDY}, 64'd1);
      chk("both_done_result", {32'd0, data_result}, 64'd30);
      start_op(1'b1, 1'b0, 32'd3, 32'd4);
      chk("b2b_issue_cycle", 64'(t0 - t1), 64'd34);
      wait_rdy("b2b");
      chk("b2b_load",   64'(last_mul_cyc - t0), 64'd1);
      chk("b2b_lat",    64'(last_rdy_cyc - t0), 64'd34);
      chk("b2b_result", {32'd0, last_res}, 64'd12);
      chk("both_div_loads", 64'(div_cnt - dc), 64'd0);
      chk("both_mul_loads", 64'(mul_cnt - mc), 64'd2);

      // 6) reset during RUN at count 10, then a clean MULT
      start_op(1'b1, 1'b0, 32'd9, 32'd9);
      repeat (11) @(posedge clock);
      #1; reset = 1'b1;
      @(posedge clock); #1; reset = 1'b0;
      chk("abort_stall", {63'd0, stall}, 64'd0);
      rc = rdy_cnt;
      repeat (40) @(posedge clock);
      #1;
      chk("abort_no_rdy", 64'(rdy_cnt - rc), 64'd0);
      start_op(1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFB);
      wait_rdy("after_abort");
      chk("after_abort_lat",    64'(last_rdy_cyc - t0), 64'd34);
      chk("after_abort_result", {32'd0, last_res}, 64'd20);
      chk("after_abort_exc",    {63'd0, last_exc}, 64'd0);

      repeat (2) @(posedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
